// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the M stage and a gnt/rvalid data bus; a misaligned access is either split into two word beats or reported as an address error.
// Latency: an aligned op with immediate gnt and rvalid one cycle later reaches DONE 3 cycles after accept; a split op adds one REQ/RSP pair.
// Backpressure: stall holds the pipeline from accept until DONE; bus fields stay stable while m_data_gnt is low.
// Ports: clk/reset; M-stage request (req_*); pipeline freeze (stall);
//        data bus master (m_data_*); load writeback (wb_*); address exceptions (exc_adel/exc_ades).
module mem_access_unit #(
    parameter int MISALIGN_EN = 1,
    parameter int RD_W        = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [RD_W-1:0] req_rd,
    output logic            stall,
    output logic            m_data_req,
    output logic            m_data_we,
    output logic [31:0]     m_data_addr,
    output logic [3:0]      m_data_byteen,
    output logic [31:0]     m_data_wdata,
    input  logic            m_data_gnt,
    input  logic            m_data_rvalid,
    input  logic [31:0]     m_data_rdata,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            exc_adel,
    output logic            exc_ades
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ0 = 3'd1;
    localparam logic [2:0] RSP0 = 3'd2;
    localparam logic [2:0] REQ1 = 3'd3;
    localparam logic [2:0] RSP1 = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    localparam logic SPLIT_EN = (MISALIGN_EN != 0);

    logic [2:0]      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic [RD_W-1:0] wb_rd_q, wb_rd_d;

    // Lane mask of the access size, right-aligned.
    function automatic logic [3:0] size_mask(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b101: size_mask = 4'b0001;
            3'b010, 3'b011, 3'b110: size_mask = 4'b0011;
            default:                size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            3'b010, 3'b011, 3'b110: misaligned = off[0];
            3'b100, 3'b111:         misaligned = (off != 2'b00);
            default:                misaligned = 1'b0;
        endcase
    endfunction

    // Shift the {hi,lo} lane pair down to the access offset and extend.
    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [63:0] pair,
                                             input logic [1:0] off);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (op)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {24'b0, sh[7:0]};
            3'b010:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b011:  load_ext = {16'b0, sh[15:0]};
            default: load_ext = sh;
        endcase
    endfunction

    logic [1:0]  off;
    logic        is_store;
    logic        cur_mis;
    logic        cur_split;
    logic        cur_exc;
    logic [3:0]  cur_mask;
    logic [7:0]  lane_en;
    logic [31:0] wdata_sized;
    logic [63:0] lane_wd;
    logic        in_req;
    logic        beat1;

    assign off       = addr_q[1:0];
    assign is_store  = op_q[2] & (op_q[1] | op_q[0]);
    assign cur_mis   = misaligned(op_q, off);
    assign cur_split = cur_mis & SPLIT_EN;
    assign cur_exc   = cur_mis & ~SPLIT_EN;
    assign cur_mask  = size_mask(op_q);

    // Byte lanes across two consecutive words; the upper half is beat 1.
    assign lane_en     = {4'b0000, cur_mask} << off;
    // Trim store data to the access size so unused lanes carry zeros.
    assign wdata_sized = wdata_q & {{8{cur_mask[3]}}, {8{cur_mask[2]}},
                                    {8{cur_mask[1]}}, {8{cur_mask[0]}}};
    assign lane_wd     = {32'b0, wdata_sized} << {off, 3'b000};

    assign in_req = (state_q == REQ0) || (state_q == REQ1);
    assign beat1  = (state_q == REQ1);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        lo_d      = lo_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    // Unsplittable misaligned access goes straight to DONE to report the error.
                    if (misaligned(req_op, req_addr[1:0]) && !SPLIT_EN) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ0;
                    end
                end
            end
            REQ0: if (m_data_gnt) state_d = RSP0;
            RSP0: begin
                if (m_data_rvalid) begin
                    lo_d = m_data_rdata;
                    if (cur_split) begin
                        state_d = REQ1;
                    end else begin
                        state_d = DONE;
                        if (!is_store) begin
                            wb_data_d = load_ext(op_q, {32'b0, m_data_rdata}, off);
                            wb_rd_d   = rd_q;
                        end
                    end
                end
            end
            REQ1: if (m_data_gnt) state_d = RSP1;
            RSP1: begin
                if (m_data_rvalid) begin
                    state_d = DONE;
                    if (!is_store) begin
                        wb_data_d = load_ext(op_q, {m_data_rdata, lo_q}, off);
                        wb_rd_d   = rd_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            lo_q      <= '0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            lo_q      <= lo_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
        end
    end

    // Bus fields are forced to zero outside the request states.
    assign m_data_req    = in_req;
    assign m_data_we     = in_req & is_store;
    assign m_data_addr   = in_req ? ({addr_q[31:2], 2'b00} + (beat1 ? 32'd4 : 32'd0)) : 32'd0;
    assign m_data_byteen = in_req ? (beat1 ? lane_en[7:4] : lane_en[3:0]) : 4'b0000;
    assign m_data_wdata  = (in_req && is_store) ? (beat1 ? lane_wd[63:32] : lane_wd[31:0]) : 32'd0;

    // Reset gates stall so every output reads zero while reset is held.
    assign stall = ~reset & (((state_q != IDLE) && (state_q != DONE)) ||
                             ((state_q == IDLE) && req_valid));

    assign wb_valid = (state_q == DONE) & ~is_store & ~cur_exc;
    assign exc_adel = (state_q == DONE) & cur_exc & ~is_store;
    assign exc_ades = (state_q == DONE) & cur_exc & is_store;
    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    // Default instance (split enabled)
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        stall, m_data_req, m_data_we;
    logic [31:0] m_data_addr, m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic        m_data_gnt = 1'b0, m_data_rvalid = 1'b0;
    logic [31:0] m_data_rdata = '0;
    logic        wb_valid, exc_adel, exc_ades;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    // Instance with misaligned accesses reported as exceptions
    logic        req_valid_n = 1'b0;
    logic [2:0]  req_op_n = '0;
    logic [31:0] req_addr_n = '0, req_wdata_n = '0;
    logic [4:0]  req_rd_n = '0;
    logic        stall_n, m_data_req_n, m_data_we_n;
    logic [31:0] m_data_addr_n, m_data_wdata_n;
    logic [3:0]  m_data_byteen_n;
    logic        wb_valid_n, exc_adel_n, exc_ades_n;
    logic [4:0]  wb_rd_n;
    logic [31:0] wb_data_n;

    mem_access_unit #(.MISALIGN_EN(1), .RD_W(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .stall(stall),
        .m_data_req(m_data_req), .m_data_we(m_data_we), .m_data_addr(m_data_addr),
        .m_data_byteen(m_data_byteen), .m_data_wdata(m_data_wdata),
        .m_data_gnt(m_data_gnt), .m_data_rvalid(m_data_rvalid), .m_data_rdata(m_data_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_adel(exc_adel), .exc_ades(exc_ades)
    );

    mem_access_unit #(.MISALIGN_EN(0), .RD_W(5)) dut_n (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_n), .req_op(req_op_n), .req_addr(req_addr_n),
        .req_wdata(req_wdata_n), .req_rd(req_rd_n), .stall(stall_n),
        .m_data_req(m_data_req_n), .m_data_we(m_data_we_n), .m_data_addr(m_data_addr_n),
        .m_data_byteen(m_data_byteen_n), .m_data_wdata(m_data_wdata_n),
        .m_data_gnt(1'b0), .m_data_rvalid(1'b0), .m_data_rdata(32'h0),
        .wb_valid(wb_valid_n), .wb_rd(wb_rd_n), .wb_data(wb_data_n),
        .exc_adel(exc_adel_n), .exc_ades(exc_ades_n)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } beat_t;
    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          cyc;
    } wb_t;
    typedef struct {
        logic adel;
        logic ades;
        int   cyc;
    } exc_t;

    beat_t beat_q[$];
    wb_t   wb_q[$];
    exc_t  exc_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int req_n_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic pb(input logic [31:0] a, input logic we, input logic [3:0] be,
                      input logic [31:0] wd);
        beat_t e;
        e.addr = a; e.we = we; e.be = be; e.wd = wd;
        beat_q.push_back(e);
    endtask

    // Monitor: compares bus beats, writebacks and exceptions against the queues.
    always @(negedge clk) begin : monitor
        beat_t e;
        wb_t   w;
        exc_t  x;
        if (!reset) begin
            if (m_data_req) begin
                chk("stall_in_bus_phase", 32'(stall), 32'd1);
                if (beat_q.size() == 0) begin
                    fail("unexpected_bus_beat");
                end else begin
                    e = beat_q[0];
                    chk("beat_addr", m_data_addr, e.addr);
                    chk("beat_we", 32'(m_data_we), 32'(e.we));
                    chk("beat_byteen", 32'(m_data_byteen), 32'(e.be));
                    chk("beat_wdata", m_data_wdata, e.wd);
                    if (m_data_gnt) void'(beat_q.pop_front());
                end
            end
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    fail("unexpected_wb_valid");
                end else begin
                    w = wb_q.pop_front();
                    chk("wb_data", wb_data, w.data);
                    chk("wb_rd", 32'(wb_rd), 32'(w.rd));
                    if (w.cyc >= 0) chk("wb_latency_cycle", cyc, w.cyc);
                end
            end
            if (exc_adel || exc_ades) fail("unexpected_exception_split_unit");
            if (m_data_req_n) req_n_cnt++;
            if (wb_valid_n) fail("unexpected_wb_valid_exc_unit");
            if (exc_adel_n || exc_ades_n) begin
                if (exc_q.size() == 0) begin
                    fail("unexpected_exception");
                end else begin
                    x = exc_q.pop_front();
                    chk("exc_adel", 32'(exc_adel_n), 32'(x.adel));
                    chk("exc_ades", 32'(exc_ades_n), 32'(x.ades));
                    chk("exc_cycle", cyc, x.cyc);
                end
            end
        end
    end

    // Issue one op and act as the bus slave. Called #1 after a rising edge with the unit idle.
    task automatic xact(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input int nb, input int gdly, input int rdly,
                        input logic [31:0] r0, input logic [31:0] r1,
                        input logic ld, input logic [31:0] exp_wb, input int lat);
        wb_t w;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rd = rd;
        if (ld) begin
            w.data = exp_wb; w.rd = rd; w.cyc = (lat >= 0) ? cyc + lat : -1;
            wb_q.push_back(w);
        end
        #1;
        chk("stall_on_accept", 32'(stall), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            int t;
            t = 0;
            while (!m_data_req && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            if (!m_data_req) begin
                fail("bus_req_timeout");
                return;
            end
            // Wiggle the request inputs while the grant is withheld; they must be ignored.
            for (int g = 0; g < gdly; g++) begin
                req_valid = 1'b1; req_op = 3'b000; req_addr = $urandom;
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
            m_data_gnt = 1'b1;
            @(posedge clk); #1;
            m_data_gnt = 1'b0;
            for (int r = 0; r < rdly; r++) begin
                @(posedge clk); #1;
            end
            m_data_rvalid = 1'b1;
            m_data_rdata  = (b == 0) ? r0 : r1;
            @(posedge clk); #1;
            m_data_rvalid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic xact_n(input logic [2:0] op, input logic [31:0] addr, input logic adel,
                          input logic ades);
        exc_t x;
        req_valid_n = 1'b1; req_op_n = op; req_addr_n = addr; req_wdata_n = 32'h5A5A5A5A; req_rd_n = 5'd3;
        x.adel = adel; x.ades = ades; x.cyc = cyc + 1;
        exc_q.push_back(x);
        @(posedge clk); #1;
        req_valid_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_m_data_req", 32'(m_data_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_byteen", 32'(m_data_byteen), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_stall", 32'(stall), 32'd0);

        // lw 0x100, aligned, immediate gnt: DONE 3 cycles after accept
        pb(32'h100, 1'b0, 4'b1111, 32'h0);
        xact(3'b100, 32'h100, 32'h0, 5'd1, 1, 0, 0, 32'h11223344, 32'h0, 1'b1, 32'h11223344, 3);

        // lh 0x103, split across two words
        pb(32'h100, 1'b0, 4'b1000, 32'h0);
        pb(32'h104, 1'b0, 4'b0001, 32'h0);
        xact(3'b010, 32'h103, 32'h0, 5'd2, 2, 0, 0, 32'hAABBCCDD, 32'h11223380, 1'b1, 32'hFFFF80AA, -1);

        // sw 0x202, split store with 3 cycles of withheld grant per beat
        pb(32'h200, 1'b1, 4'b1100, 32'hBEEF0000);
        pb(32'h204, 1'b1, 4'b0011, 32'h0000DEAD);
        xact(3'b111, 32'h202, 32'hDEADBEEF, 5'd9, 2, 3, 1, 32'h0, 32'h0, 1'b0, 32'h0, -1);
        chk("wb_data_hold_after_store", wb_data, 32'hFFFF80AA);
        chk("wb_rd_hold_after_store", 32'(wb_rd), 32'd2);

        // lhu 0x102 with slow response
        pb(32'h100, 1'b0, 4'b1100, 32'h0);
        xact(3'b011, 32'h102, 32'h0, 5'd3, 1, 0, 2, 32'h80010000, 32'h0, 1'b1, 32'h00008001, -1);

        // lb 0x001, sign extension
        pb(32'h000, 1'b0, 4'b0010, 32'h0);
        xact(3'b000, 32'h001, 32'h0, 5'd4, 1, 1, 0, 32'h00008000, 32'h0, 1'b1, 32'hFFFFFF80, -1);

        // sb 0x003 and sh 0x0FE: unused store bits must not reach the bus
        pb(32'h000, 1'b1, 4'b1000, 32'h78000000);
        xact(3'b101, 32'h003, 32'h12345678, 5'd0, 1, 0, 0, 32'h0, 32'h0, 1'b0, 32'h0, -1);
        pb(32'h0FC, 1'b1, 4'b1100, 32'h56780000);
        xact(3'b110, 32'h0FE, 32'h12345678, 5'd0, 1, 0, 0, 32'h0, 32'h0, 1'b0, 32'h0, -1);

        // lw 0xFFFFFFFF: second beat address wraps to 0
        pb(32'hFFFFFFFC, 1'b0, 4'b1000, 32'h0);
        pb(32'h00000000, 1'b0, 4'b0111, 32'h0);
        xact(3'b100, 32'hFFFFFFFF, 32'h0, 5'd5, 2, 0, 0, 32'hAA000000, 32'h00CCBBDD, 1'b1, 32'hCCBBDDAA, -1);

        // sw 0x201, split store at offset 1
        pb(32'h200, 1'b1, 4'b1110, 32'hB2C3D400);
        pb(32'h204, 1'b1, 4'b0001, 32'h000000A1);
        xact(3'b111, 32'h201, 32'hA1B2C3D4, 5'd0, 2, 0, 0, 32'h0, 32'h0, 1'b0, 32'h0, -1);

        // Reset while waiting for the response, then a late rvalid
        pb(32'h300, 1'b0, 4'b1111, 32'h0);
        req_valid = 1'b1; req_op = 3'b100; req_addr = 32'h300; req_rd = 5'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        m_data_gnt = 1'b1;
        @(posedge clk); #1;
        m_data_gnt = 1'b0;
        reset = 1'b1;
        req_valid = 1'b1;
        #1;
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_m_data_req", 32'(m_data_req), 32'd0);
        chk("midrst_m_data_addr", m_data_addr, 32'd0);
        chk("midrst_byteen", 32'(m_data_byteen), 32'd0);
        chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("midrst_wb_data", wb_data, 32'd0);
        chk("midrst_wb_rd", 32'(wb_rd), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 1'b0;
        m_data_rvalid = 1'b1;
        m_data_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        m_data_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle_stall", 32'(stall), 32'd0);

        // lbu 0x003 after reset: zero extension
        pb(32'h000, 1'b0, 4'b1000, 32'h0);
        xact(3'b001, 32'h003, 32'h0, 5'd9, 1, 0, 0, 32'h80000000, 32'h0, 1'b1, 32'h00000080, 3);

        // Exception-reporting instance
        xact_n(3'b100, 32'h101, 1'b1, 1'b0);
        xact_n(3'b110, 32'h201, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("beat_queue_drained", 32'(beat_q.size()), 32'd0);
        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        chk("exc_queue_drained", 32'(exc_q.size()), 32'd0);
        chk("exc_unit_bus_req_cycles", 32'(req_n_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MISALIGN_EN, default 1; 1 = split misaligned accesses into two bus beats, 0 = raise an address exception.
REQ-002 SHALL have parameter RD_W, default 5; destination-register index width.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports clk, reset.
REQ-004 Ports (name dir width meaning):
- clk  in  1  clock
- reset  in  1  async active-high reset
- req_valid  in  1  M-stage memory op present
- req_op  in  3  000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw, 101 sb, 110 sh, 111 sw
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_rd  in  RD_W  load destination
- stall  out  1  freeze pipeline
- m_data_req  out  1  bus request
- m_data_we  out  1  bus write
- m_data_addr  out  32  word-aligned bus address
- m_data_byteen  out  4  lane enables
- m_data_wdata  out  32  lane-positioned write data
- m_data_gnt  in  1  request accepted this cycle
- m_data_rvalid  in  1  response (read data or store ack)
- m_data_rdata  in  32  read data
- wb_valid  out  1  load result valid
- wb_rd  out  RD_W  load destination
- wb_data  out  32  extended load data
- exc_adel  out  1  load address error
- exc_ades  out  1  store address error

Function
REQ-005 SHALL use states IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
REQ-006 In IDLE with req_valid=1, SHALL capture op/addr/wdata/rd and go to REQ0; if misaligned with MISALIGN_EN=0, SHALL go to DONE directly, issuing no bus request.
REQ-007 Misaligned: half with addr[0]=1, word with addr[1:0]!=0; bytes never misaligned.
REQ-008 split = misaligned and MISALIGN_EN=1; off = addr[1:0]; mask = 0001/0011/1111 for byte/half/word.
REQ-009 Beat0: address {addr[31:2],2'b00}, byteen = (mask<<off)[3:0], wdata = (wdata<<8*off)[31:0].
REQ-010 Beat1 (split only): address beat0+4 (wraps mod 2^32), byteen = (mask<<off)[7:4], wdata = (wdata<<8*off)[63:32].
REQ-011 Disabled lanes of m_data_wdata SHALL be 0.
REQ-012 In REQ0/REQ1: m_data_req=1; addr/we/byteen/wdata held stable until m_data_gnt=1, then go to RSP0/RSP1.
REQ-013 In RSP0/RSP1, SHALL wait for m_data_rvalid; in RSP0 capture rdata as lo; in RSP1 capture as hi.
REQ-014 On RSP0 rvalid, SHALL go to REQ1 if split, else DONE; on RSP1 rvalid, SHALL go to DONE.
REQ-015 Load result SHALL be ({hi,lo}>>8*off), low 8/16/32 bits, sign-extended (lb, lh) or zero-extended (lbu, lhu).
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-017 In DONE, wb_valid=1 for loads with no exception; exc_adel/exc_ades=1 for the exception case; all other cycles these are 0.
REQ-018 wb_data/wb_rd SHALL hold their last value outside DONE.
REQ-019 stall SHALL equal (state not IDLE and not DONE) or (state==IDLE and req_valid).
REQ-020 req_valid SHALL be ignored outside IDLE.
REQ-021 m_data_rvalid received in IDLE/REQ0/REQ1/DONE SHALL be discarded.
REQ-022 Aligned load with gnt in its first REQ0 cycle and rvalid one cycle later: DONE occurs 3 cycles after the accept cycle.

Reset
REQ-023 reset=1 SHALL immediately force IDLE and drive every output to 0, including wb_data/wb_rd; an in-flight transaction is abandoned.

Verification
REQ-024 lw 0x100, gnt immediate, rdata 0x11223344 -> one bus beat, addr 0x100, byteen 1111, wb_data 0x11223344, wb_valid for 1 cycle, 3 cycles after accept.
REQ-025 lh 0x103, MISALIGN_EN=1 -> beat0: addr 0x100, byteen 1000, rdata 0xAABBCCDD; beat1: addr 0x104, byteen 0001, rdata 0x11223380; result wb_data 0xFFFF80AA.
REQ-026 sw 0x202, wdata 0xDEADBEEF -> beat0: addr 0x200, byteen 1100, wdata 0xBEEF0000; beat1: addr 0x204, byteen 0011, wdata 0x0000DEAD; wb_valid stays 0.
REQ-027 MISALIGN_EN=0, lw 0x101 -> m_data_req never 1, exc_adel=1 for one cycle, wb_valid=0; sh 0x201 -> exc_ades=1.
REQ-028 gnt low for 3 cycles -> m_data_req, addr, byteen and wdata constant; stall=1 throughout; changes on req_valid/req_addr ignored.
REQ-029 reset asserted in RSP0, late rvalid after release -> all outputs 0 at once, rvalid discarded, no wb_valid, next lbu 0x003 with rdata 0x80000000 -> wb_data 0x00000080.
